tile_config_ctrl: RTL and testbench
===================================

Name: tile_config_ctrl

Overview:
- Parametrised configuration front end for a fabric tile.
- Replaces the per-target fixed address matchers with a single block that:
  - decodes the global config bus (tile id, target id, beat index);
  - assembles multi-beat words for config fields wider than 32 bits;
  - holds NUM_TARGETS active config registers;
  - commits each register atomically, with a one-cycle config_en pulse;
  - supports readback.
- Sits between the global config chain and the tile's PE, switch box and connect boxes.

Parameters:
- NUM_TARGETS, 4, number of config targets (PE, SB, CB0, CB1, ...); range 1..256.
- CFG_WIDTH, 32, width of each target's config register; range 1..256. Derived BEATS = ceil(CFG_WIDTH/32).
- BCAST_ID, 16'hFFFF, tile id that matches every tile for writes.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous reset, active-low.
- tile_id  in  16  this tile's id; static after reset.
- config_valid  in  1  request valid.
- config_ready  out  1  controller can accept a request this cycle.
- config_we  in  1  1 = write, 0 = read.
- config_addr  in  32  [31:16] tile id, [15:8] target id, [7:0] beat index.
- config_data  in  32  write data for one beat.
- read_data  out  32  readback word.
- read_valid  out  1  read_data valid, one-cycle pulse.
- cfg_error  out  1  one-cycle pulse on a rejected matched request.
- config_en  out  NUM_TARGETS  one-hot one-cycle commit pulse per target.
- cfg_out  out  NUM_TARGETS*CFG_WIDTH  active registers; target t occupies bits [t*CFG_WIDTH +: CFG_WIDTH].

Behaviour:
- Reset (reset=0, asynchronous) forces the following; it takes effect mid-operation too.
  - State = IDLE.
  - All active registers and the shadow register are 0; pending target is invalid.
  - config_ready=0 while reset is asserted, and 1 from the first clk after release.
  - read_data, read_valid, cfg_error and config_en are all 0.
  - A half-assembled multi-beat write is lost.
- Handshake: a request is accepted on a clk edge where config_valid && config_ready. Inputs are sampled only on acceptance.
- Match rules:
  - Write matches if addr tile == tile_id or addr tile == BCAST_ID.
  - Read matches only if addr tile == tile_id; broadcast reads are ignored.
  - Non-matching requests are accepted and dropped silently: no error, no read_valid.
- Error (matched request only), on any of:
  - target >= NUM_TARGETS;
  - beat >= BEATS;
  - write with beat>0 whose target != pending target;
  - write with beat>0 when no write is pending.
- Error consequences:
  - cfg_error pulses the cycle after acceptance.
  - An erroring write changes nothing.
  - An erroring read pulses read_valid with read_data=0.
- FSM states: IDLE, COMMIT.
  - In IDLE, config_ready=1.
  - Write beat 0: sets pending target; shadow[31:0] = data. Any partial write pending for another target is discarded.
  - Write beat k (valid): shadow[32k+:32] = data.
  - If the accepted valid write beat == BEATS-1, go to COMMIT. With BEATS=1, every valid write commits.
  - In COMMIT, config_ready=0 for exactly one cycle:
    - active[pending] = shadow[CFG_WIDTH-1:0];
    - config_en[pending] is set, visible the same cycle cfg_out updates, i.e. the cycle after entry;
    - the shadow is cleared and pending is invalidated;
    - next state is IDLE.
- Latencies:
  - Write of the last beat to config_en high and cfg_out updated: 2 cycles after acceptance. Back-to-back max throughput is one commit per BEATS+1 cycles.
  - Read: read_data = active[target][32*beat +: 32], zero-extended past CFG_WIDTH, with read_valid=1 exactly one cycle after acceptance.
  - A read does not disturb a pending multi-beat write.
  - Read of a target in the same cycle its commit lands returns the newly committed value.
- Bits of config_data beyond CFG_WIDTH in the top beat are ignored.

Test Plan:
- Reset then single write, CFG_WIDTH=32, tile_id=3: write addr 0x0003_0100 data 0xDEADBEEF.
  - Expect config_en=4'b0010 for one cycle.
  - Expect cfg_out[63:32]=0xDEADBEEF and all other fields 0.
- Multi-beat, CFG_WIDTH=72 (BEATS=3): write target 2, beats 0,1,2 with 0x11111111, 0x22222222, 0x000000AB.
  - Expect one config_en[2] pulse after beat 2 only.
  - Expect field = 72'hAB_22222222_11111111.
  - Read beat 2 returns 0x000000AB.
- Broadcast and mismatch: write tile 0xFFFF target 0 data 5 → commit. Write tile 7 (tile_id=3) → no config_en and no error. Read tile 0xFFFF → no read_valid.
- Errors:
  - Write target 9 with NUM_TARGETS=4 → cfg_error pulse, cfg_out unchanged.
  - Beat 1 to target 1 while target 0 pending → cfg_error; the target 0 write still completes afterwards.
- Handshake: hold config_valid high with back-to-back single-beat writes → config_ready low exactly one cycle after each last beat; no request lost or duplicated.
- Reset mid-assembly: assert reset after beat 1 of 3 → all outputs 0 asynchronously. After release, beat 2 write → cfg_error, no commit.

Source files
------------

// File: rtl/tile_config_ctrl.sv
// Config bus front end: decodes tile/target/beat, assembles wide words in a shadow register, commits atomically.
// Read data 1 cycle after accept; commit lands 2 cycles after last beat; config_ready drops for the single commit cycle.
module tile_config_ctrl #(
    parameter int          NUM_TARGETS = 4,
    parameter int          CFG_WIDTH   = 32,
    parameter logic [15:0] BCAST_ID    = 16'hFFFF
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [15:0]                      tile_id,
    input  logic                             config_valid,
    output logic                             config_ready,
    input  logic                             config_we,
    input  logic [31:0]                      config_addr,
    input  logic [31:0]                      config_data,
    output logic [31:0]                      read_data,
    output logic                             read_valid,
    output logic                             cfg_error,
    output logic [NUM_TARGETS-1:0]           config_en,
    output logic [NUM_TARGETS*CFG_WIDTH-1:0] cfg_out
);
    localparam int BEATS = (CFG_WIDTH + 31) / 32;
    localparam int SH_W  = BEATS * 32;

    typedef enum logic {IDLE, COMMIT} state_t;

    state_t          state;
    logic [SH_W-1:0] shadow;
    logic [7:0]      pend_tgt;
    logic            pend_vld;

    logic [15:0]     a_tile;
    logic [7:0]      a_tgt;
    logic [7:0]      a_beat;
    logic            accept;
    logic            match;
    logic            tgt_ok;
    logic            beat_ok;
    logic            seq_ok;
    logic            err;
    logic            last_beat;
    logic [SH_W-1:0] rd_word;

    assign a_tile    = config_addr[31:16];
    assign a_tgt     = config_addr[15:8];
    assign a_beat    = config_addr[7:0];
    assign accept    = config_valid && config_ready;
    // Broadcast id only matches writes; reads must name this tile exactly.
    assign match     = config_we ? (a_tile == tile_id || a_tile == BCAST_ID)
                                 : (a_tile == tile_id);
    assign tgt_ok    = int'(a_tgt) < NUM_TARGETS;
    assign beat_ok   = int'(a_beat) < BEATS;
    assign seq_ok    = !config_we || (a_beat == 8'd0) || (pend_vld && a_tgt == pend_tgt);
    assign err       = !(tgt_ok && beat_ok && seq_ok);
    assign last_beat = int'(a_beat) == BEATS - 1;

    // Active field zero-extended to whole beats so the top beat reads back clean.
    always_comb begin
        rd_word = '0;
        if (tgt_ok) begin
            rd_word[CFG_WIDTH-1:0] = cfg_out[int'(a_tgt)*CFG_WIDTH +: CFG_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            shadow       <= '0;
            pend_tgt     <= '0;
            pend_vld     <= 1'b0;
            config_ready <= 1'b0;
            read_data    <= '0;
            read_valid   <= 1'b0;
            cfg_error    <= 1'b0;
            config_en    <= '0;
            cfg_out      <= '0;
        end else begin
            read_valid <= 1'b0;
            cfg_error  <= 1'b0;
            config_en  <= '0;
            read_data  <= '0;
            case (state)
                IDLE: begin
                    config_ready <= 1'b1;
                    if (accept && match) begin
                        cfg_error <= err;
                        if (!config_we) begin
                            read_valid <= 1'b1;
                            if (!err) begin
                                read_data <= rd_word[int'(a_beat)*32 +: 32];
                            end
                        end else if (!err) begin
                            if (a_beat == 8'd0) begin
                                // A fresh beat 0 abandons any half-built word.
                                shadow   <= SH_W'(config_data);
                                pend_tgt <= a_tgt;
                                pend_vld <= 1'b1;
                            end else begin
                                shadow[int'(a_beat)*32 +: 32] <= config_data;
                            end
                            if (last_beat) begin
                                state        <= COMMIT;
                                config_ready <= 1'b0;
                            end
                        end
                    end
                end
                COMMIT: begin
                    cfg_out[int'(pend_tgt)*CFG_WIDTH +: CFG_WIDTH] <= shadow[CFG_WIDTH-1:0];
                    config_en    <= NUM_TARGETS'(1) << pend_tgt;
                    shadow       <= '0;
                    pend_vld     <= 1'b0;
                    state        <= IDLE;
                    config_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tile_config_ctrl.sv
// Bench for tile_config_ctrl: a 32-bit and a 72-bit instance, each checked against a transaction-level model.
module tb_tile_config_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] tid = 16'h0003;
    logic        cv[2];
    logic        cwe[2];
    logic [31:0] caddr[2];
    logic [31:0] cdata[2];
    logic        rdy[2];
    logic        rv[2];
    logic        er[2];
    logic [31:0] rd[2];
    logic [3:0]  cen[2];
    logic [127:0] co32;
    logic [287:0] co72;

    int tests = 0;
    int fails = 0;

    // Model state: committed values, assembly words, pending target.
    logic [95:0] m_act[2][4];
    logic [31:0] m_sh[2][3];
    bit          m_pv[2];
    int          m_pt[2];
    int          beats[2]  = '{1, 3};
    int          widths[2] = '{32, 72};

    always #5 clk = ~clk;

    tile_config_ctrl #(.NUM_TARGETS(4), .CFG_WIDTH(32), .BCAST_ID(16'hFFFF)) dut32 (
        .clk(clk), .reset(rst_n), .tile_id(tid),
        .config_valid(cv[0]), .config_ready(rdy[0]), .config_we(cwe[0]),
        .config_addr(caddr[0]), .config_data(cdata[0]),
        .read_data(rd[0]), .read_valid(rv[0]), .cfg_error(er[0]),
        .config_en(cen[0]), .cfg_out(co32)
    );

    tile_config_ctrl #(.NUM_TARGETS(4), .CFG_WIDTH(72), .BCAST_ID(16'hFFFF)) dut72 (
        .clk(clk), .reset(rst_n), .tile_id(tid),
        .config_valid(cv[1]), .config_ready(rdy[1]), .config_we(cwe[1]),
        .config_addr(caddr[1]), .config_data(cdata[1]),
        .read_data(rd[1]), .read_valid(rv[1]), .cfg_error(er[1]),
        .config_en(cen[1]), .cfg_out(co72)
    );

    function automatic logic [95:0] mask(input int i);
        return (96'd1 << widths[i]) - 96'd1;
    endfunction

    function automatic logic [95:0] fld(input int i, input int t);
        if (i == 0) return {64'b0, co32[t*32 +: 32]};
        return {24'b0, co72[t*72 +: 72]};
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_fields(input int i);
        for (int t = 0; t < 4; t++) chk("field", fld(i, t), m_act[i][t]);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pv[i] = 0;
            m_pt[i] = 0;
            for (int t = 0; t < 4; t++) m_act[i][t] = '0;
            for (int b = 0; b < 3; b++) m_sh[i][b] = '0;
        end
    endtask

    task automatic send(input int i, input logic we, input logic [15:0] tile,
                        input int tgt, input int beat, input logic [31:0] d);
        logic        match;
        logic        err;
        logic        commit;
        logic [31:0] exp_rd;
        int          n;
        match  = we ? (tile == tid || tile == 16'hFFFF) : (tile == tid);
        err    = match && (tgt >= 4 || beat >= beats[i] ||
                           (we && beat > 0 && (!m_pv[i] || m_pt[i] != tgt)));
        commit = 1'b0;
        exp_rd = '0;
        if (match && !err) begin
            if (!we) begin
                exp_rd = 32'(m_act[i][tgt] >> (32 * beat));
            end else begin
                if (beat == 0) begin
                    m_pv[i] = 1;
                    m_pt[i] = tgt;
                    for (int b = 0; b < 3; b++) m_sh[i][b] = '0;
                end
                m_sh[i][beat] = d;
                if (beat == beats[i] - 1) begin
                    m_act[i][tgt] = {m_sh[i][2], m_sh[i][1], m_sh[i][0]} & mask(i);
                    m_pv[i] = 0;
                    commit = 1'b1;
                end
            end
        end
        @(negedge clk);
        n = 0;
        while (rdy[i] !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rdy_wait", rdy[i], 1);
        cv[i] = 1'b1; cwe[i] = we;
        caddr[i] = {tile, 8'(tgt), 8'(beat)};
        cdata[i] = d;
        @(negedge clk);
        cv[i] = 1'b0;
        chk("cfg_error", er[i], err);
        chk("read_valid", rv[i], match && !we);
        if (match && !we) chk("read_data", rd[i], exp_rd);
        chk("en_early", cen[i], 0);
        chk("rdy_after", rdy[i], !commit);
        @(negedge clk);
        chk("config_en", cen[i], commit ? (4'b1 << tgt) : 4'b0);
        chk("err_pulse", er[i], 0);
        chk_fields(i);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  e1, e2;
        logic [31:0] hd[6];
        int          k, pulses, tg;
        logic        acc, exp_rdy;
        for (int i = 0; i < 2; i++) begin
            cv[i] = 0; cwe[i] = 0; caddr[i] = '0; cdata[i] = '0;
        end
        model_reset();

        // Reset state, then first clk after release raises ready.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_rdy", rdy[i], 0);
            chk("rst_en", cen[i], 0);
            chk("rst_rv", rv[i], 0);
            chk_fields(i);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_release", rdy[0], 1);
        chk("rdy_release", rdy[1], 1);

        // Single-beat write to target 1.
        send(0, 1, 16'h0003, 1, 0, 32'hDEADBEEF);
        chk("tp1_field", co32[63:32], 32'hDEADBEEF);

        // Three-beat write, then readback of the top beat.
        send(1, 1, 16'h0003, 2, 0, 32'h11111111);
        send(1, 1, 16'h0003, 2, 1, 32'h22222222);
        send(1, 1, 16'h0003, 2, 2, 32'h000000AB);
        chk("mb_field", fld(1, 2), 96'h00AB_2222_2222_1111_1111);
        send(1, 0, 16'h0003, 2, 2, 32'h0);

        // Broadcast write, foreign tile, broadcast read.
        send(0, 1, 16'hFFFF, 0, 0, 32'h5);
        send(0, 1, 16'h0007, 2, 0, 32'h12345678);
        send(0, 0, 16'hFFFF, 0, 0, 32'h0);

        // Error cases.
        send(0, 1, 16'h0003, 9, 0, 32'hCAFE0000);
        send(1, 1, 16'h0003, 0, 0, 32'hA0A0A0A0);
        send(1, 1, 16'h0003, 1, 1, 32'hBADBAD00);
        send(1, 1, 16'h0003, 0, 1, 32'hB1B1B1B1);
        send(1, 1, 16'h0003, 0, 2, 32'hFFFFFFC2);
        send(1, 0, 16'h0003, 0, 3, 32'h0);

        // Held valid, back-to-back single-beat writes.
        for (int j = 0; j < 6; j++) hd[j] = $urandom;
        @(negedge clk);
        k = 0; pulses = 0; e1 = '0; e2 = '0; exp_rdy = 1'b1;
        cv[0] = 1'b1; cwe[0] = 1'b1; caddr[0] = {16'h0003, 8'd0, 8'd0}; cdata[0] = hd[0];
        for (int c = 0; c < 14; c++) begin
            chk("hs_rdy", rdy[0], exp_rdy);
            acc = rdy[0] && cv[0];
            tg  = k % 4;
            @(negedge clk);
            e2 = e1;
            e1 = acc ? (4'b1 << tg) : 4'b0;
            exp_rdy = !acc;
            if (cen[0] != 4'b0) pulses++;
            chk("hs_en", cen[0], e2);
            if (acc) begin
                m_act[0][tg] = {64'b0, hd[k]};
                k++;
                if (k < 6) begin
                    caddr[0] = {16'h0003, 8'(k % 4), 8'd0};
                    cdata[0] = hd[k];
                end else begin
                    cv[0] = 1'b0;
                end
            end
        end
        chk("hs_accepts", k, 6);
        chk("hs_pulses", pulses, 6);
        chk_fields(0);

        // Reset in the middle of a three-beat assembly.
        send(1, 1, 16'h0003, 1, 0, 32'h01010101);
        send(1, 1, 16'h0003, 1, 1, 32'h02020202);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            chk("mid_rdy", rdy[i], 0);
            chk("mid_en", cen[i], 0);
            chk("mid_rv", rv[i], 0);
            chk("mid_err", er[i], 0);
            chk("mid_rd", rd[i], 0);
            chk_fields(i);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_release", rdy[1], 1);
        send(1, 1, 16'h0003, 1, 2, 32'h03030303);

        // Randomized traffic against the model.
        for (int it = 0; it < 80; it++) begin
            int          i, t, b;
            logic [15:0] tl;
            i = $urandom_range(1, 0);
            if (i == 1 && $urandom_range(2, 0) == 0) begin
                t = $urandom_range(3, 0);
                for (int bb = 0; bb < 3; bb++) begin
                    send(1, 1, 16'h0003, t, bb, $urandom);
                    if ($urandom_range(3, 0) == 0)
                        send(1, 0, 16'h0003, $urandom_range(3, 0), $urandom_range(2, 0), 32'h0);
                end
            end else begin
                case ($urandom_range(3, 0))
                    0, 1:    tl = 16'h0003;
                    2:       tl = 16'hFFFF;
                    default: tl = 16'h0007;
                endcase
                t = $urandom_range(5, 0);
                b = $urandom_range(beats[i], 0);
                send(i, 1'($urandom_range(1, 0)), tl, t, b, $urandom);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
